// File: rtl/axi_lite_mmio_regs.sv
// AXI4-Lite register window for the RISC-V subsystem: CTRL (core reset), STATUS, scratch registers.
// B follows one cycle after AW and W are both held; R follows one cycle after AR.
module axi_lite_mmio_regs #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                             S_AXI_ACLK,
   input  logic                             S_AXI_ARESET,
   input  logic [ADDR_WIDTH-1:0]            S_AXI_AWADDR,
   input  logic                             S_AXI_AWVALID,
   output logic                             S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]            S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
   input  logic                             S_AXI_WVALID,
   output logic                             S_AXI_WREADY,
   output logic [1:0]                       S_AXI_BRESP,
   output logic                             S_AXI_BVALID,
   input  logic                             S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
   input  logic                             S_AXI_ARVALID,
   output logic                             S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]            S_AXI_RDATA,
   output logic [1:0]                       S_AXI_RRESP,
   output logic                             S_AXI_RVALID,
   input  logic                             S_AXI_RREADY,
   input  logic [DATA_WIDTH-1:0]            status_in,
   output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] scratch_out,
   output logic                             riscv_rst
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_WIDTH  = ADDR_WIDTH - 2;
   localparam logic [IDX_WIDTH:0] REG_COUNT = (IDX_WIDTH + 1)'(NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                  aw_held, w_held, bvalid, rvalid, ctrl_run;
   logic [IDX_WIDTH-1:0]  aw_idx, ar_idx;
   logic [DATA_WIDTH-1:0] w_data, rdata, rd_data;
   logic [STRB_WIDTH-1:0] w_strb;
   logic [1:0]            bresp, rresp, rd_resp;
   logic                  aw_hs, w_hs, ar_hs;
   logic [DATA_WIDTH-1:0] scratch [NUM_REGS-2];
   logic                  unused_addr_lsbs;

   assign S_AXI_AWREADY = ~aw_held & ~bvalid & ~S_AXI_ARESET;
   assign S_AXI_WREADY  = ~w_held  & ~bvalid & ~S_AXI_ARESET;
   assign S_AXI_ARREADY = ~rvalid & ~S_AXI_ARESET;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_BRESP   = bresp;
   assign S_AXI_RVALID  = rvalid;
   assign S_AXI_RRESP   = rresp;
   assign S_AXI_RDATA   = rdata;
   assign riscv_rst     = ~ctrl_run;

   assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
   assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   for (genvar g = 0; g < NUM_REGS - 2; g++) begin : g_scratch_out
      assign scratch_out[g*DATA_WIDTH +: DATA_WIDTH] = scratch[g];
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_idx   <= '0;
         w_data   <= '0;
         w_strb   <= '0;
         bvalid   <= 1'b0;
         bresp    <= RESP_OKAY;
         ctrl_run <= 1'b0;
         for (int k = 0; k < NUM_REGS - 2; k++) scratch[k] <= '0;
      end else begin
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         // Commit: STATUS and unmapped indices fall through to SLVERR untouched
         if (aw_held && w_held) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= RESP_SLVERR;
            if (aw_idx == '0) begin
               bresp <= RESP_OKAY;
               if (w_strb[0]) ctrl_run <= w_data[0];
            end
            for (int k = 2; k < NUM_REGS; k++) begin
               if (aw_idx == IDX_WIDTH'(k)) begin
                  bresp <= RESP_OKAY;
                  for (int b = 0; b < STRB_WIDTH; b++)
                     if (w_strb[b]) scratch[k-2][8*b +: 8] <= w_data[8*b +: 8];
               end
            end
         end else if (bvalid && S_AXI_BREADY) begin
            bvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      rd_resp = ({1'b0, ar_idx} < REG_COUNT) ? RESP_OKAY : RESP_SLVERR;
      if (ar_idx == '0) rd_data[0] = ctrl_run;
      if (ar_idx == IDX_WIDTH'(1)) rd_data = status_in;
      for (int k = 2; k < NUM_REGS; k++)
         if (ar_idx == IDX_WIDTH'(k)) rd_data = scratch[k-2];
   end

   // Read sees pre-commit register values when a write commits on the same edge
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rdata  <= rd_data;
         rresp  <= rd_resp;
      end else if (rvalid && S_AXI_RREADY) begin
         rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_lite_mmio_regs.sv
// Bench for axi_lite_mmio_regs: table of write/read-back vectors plus directed corner sequences,
// with B/R responses checked against queued expectations.
module tb_axi_lite_mmio_regs;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [9:0]   awaddr = '0, araddr = '0;
   logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic         bready = 1'b1, rready = 1'b1;
   logic [31:0]  wdata = '0, status_in = 32'hCAFE0001;
   logic [3:0]   wstrb = '0;
   logic         awready, wready, bvalid, arready, rvalid, riscv_rst;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [191:0] scratch_out;

   int checks = 0;
   int errors = 0;
   int b_seen = 0;
   int r_seen = 0;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
   } rexp_t;

   typedef struct {
      logic [9:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          aw_dly;
      int          w_dly;
      logic [1:0]  bresp;
      logic [9:0]  raddr;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rst_exp;
   } vec_t;

   logic [1:0] exp_b_q [$];
   rexp_t      exp_r_q [$];
   vec_t       vecs [11];

   always #5 clk = ~clk;

   axi_lite_mmio_regs dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .status_in(status_in), .scratch_out(scratch_out), .riscv_rst(riscv_rst)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Responses are sampled on the falling edge before the handshake edge.
   always @(negedge clk) begin
      if (bvalid && bready) begin
         if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
         else check($sformatf("bresp#%0d", b_seen), bresp, exp_b_q.pop_front());
         b_seen++;
      end
      if (rvalid && rready) begin
         if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
         else begin
            rexp_t e;
            e = exp_r_q.pop_front();
            check($sformatf("rdata#%0d", r_seen), rdata, e.d);
            check($sformatf("rresp#%0d", r_seen), rresp, e.r);
         end
         r_seen++;
      end
   end

   task automatic wait_chan(input int which, input string name);
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if ((which == 0 && awready) || (which == 1 && wready) || (which == 2 && arready)) begin
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      if (!done) check(name, 0, 1);
   endtask

   task automatic wait_count(input int which, input int target, input string name);
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         if ((which == 0 ? b_seen : r_seen) >= target) done = 1;
         else @(posedge clk);
      end
      if (!done) check(name, 0, 1);
   endtask

   task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input logic [1:0] er);
      int target;
      target = b_seen + 1;
      exp_b_q.push_back(er);
      @(posedge clk);
      #1;
      fork
         begin
            repeat (aw_dly) begin @(posedge clk); #1; end
            awaddr = a; awvalid = 1'b1;
            wait_chan(0, "aw_timeout");
            awvalid = 1'b0;
         end
         begin
            repeat (w_dly) begin @(posedge clk); #1; end
            wdata = d; wstrb = s; wvalid = 1'b1;
            wait_chan(1, "w_timeout");
            wvalid = 1'b0;
         end
      join
      wait_count(0, target, "b_timeout");
   endtask

   task automatic do_read(input logic [9:0] a, input logic [31:0] ed, input logic [1:0] er);
      int target;
      target = r_seen + 1;
      exp_r_q.push_back('{d: ed, r: er});
      @(posedge clk);
      #1;
      araddr = a; arvalid = 1'b1;
      wait_chan(2, "ar_timeout");
      arvalid = 1'b0;
      wait_count(1, target, "r_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{10'h000, 32'h00000001, 4'hF, 0, 0, 2'b00, 10'h000, 32'h00000001, 2'b00, 1'b0};
      vecs[1]  = '{10'h008, 32'h11223344, 4'hF, 0, 0, 2'b00, 10'h008, 32'h11223344, 2'b00, 1'b0};
      vecs[2]  = '{10'h008, 32'hDEADBEEF, 4'h5, 5, 0, 2'b00, 10'h008, 32'h11AD33EF, 2'b00, 1'b0};
      vecs[3]  = '{10'h004, 32'hFFFFFFFF, 4'hF, 0, 2, 2'b10, 10'h004, 32'hCAFE0001, 2'b00, 1'b0};
      vecs[4]  = '{10'h020, 32'h12345678, 4'hF, 2, 0, 2'b10, 10'h020, 32'h00000000, 2'b10, 1'b0};
      vecs[5]  = '{10'h01C, 32'hA5A5A5A5, 4'h0, 0, 0, 2'b00, 10'h01C, 32'h00000000, 2'b00, 1'b0};
      vecs[6]  = '{10'h01C, 32'hA5A5A5A5, 4'hC, 1, 1, 2'b00, 10'h01C, 32'hA5A50000, 2'b00, 1'b0};
      vecs[7]  = '{10'h013, 32'h0000BEEF, 4'h3, 0, 0, 2'b00, 10'h010, 32'h0000BEEF, 2'b00, 1'b0};
      vecs[8]  = '{10'h3FC, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 10'h3FC, 32'h00000000, 2'b10, 1'b0};
      vecs[9]  = '{10'h000, 32'hFFFFFFFE, 4'hF, 0, 0, 2'b00, 10'h000, 32'h00000000, 2'b00, 1'b1};
      vecs[10] = '{10'h000, 32'h00000003, 4'h1, 0, 3, 2'b00, 10'h000, 32'h00000001, 2'b00, 1'b0};

      // Reset state
      #12;
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_riscv_rst", riscv_rst, 1);
      check("rst_scratch", scratch_out[63:0], 0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      check("idle_awready", awready, 1);
      check("idle_wready", wready, 1);
      check("idle_arready", arready, 1);

      for (int i = 0; i < 11; i++) begin
         do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].aw_dly, vecs[i].w_dly,
                  vecs[i].bresp);
         do_read(vecs[i].raddr, vecs[i].rdata, vecs[i].rresp);
         check($sformatf("vec%0d_riscv_rst", i), riscv_rst, vecs[i].rst_exp);
      end
      check("scratch2_out", scratch_out[31:0], 32'h11AD33EF);
      check("scratch7_out", scratch_out[5*32 +: 32], 32'hA5A50000);

      // B held off for 10 cycles: response stable, no new AW/W accepted
      bready = 1'b0;
      fork
         do_write(10'h018, 32'h0F0F0F0F, 4'hF, 0, 0, 2'b00);
         begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
               @(negedge clk);
               seen = bvalid;
            end
            if (!seen) check("hold_bvalid_timeout", 0, 1);
            repeat (10) begin
               @(negedge clk);
               check("hold_bvalid", bvalid, 1);
               check("hold_bresp", bresp, 2'b00);
               check("hold_awready", awready, 0);
               check("hold_wready", wready, 0);
            end
            @(posedge clk); #1;
            bready = 1'b1;
         end
      join
      do_write(10'h018, 32'h12345678, 4'h3, 0, 0, 2'b00);
      do_read(10'h018, 32'h0F0F5678, 2'b00);

      // Read and write commit on the same edge to 0x00C
      begin
         int bt, rt;
         bt = b_seen + 1;
         rt = r_seen + 1;
         exp_b_q.push_back(2'b00);
         exp_r_q.push_back('{d: 32'h0, r: 2'b00});
         @(posedge clk); #1;
         awaddr = 10'h00C; awvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
         @(negedge clk);
         check("same_awready", awready, 1);
         check("same_wready", wready, 1);
         @(posedge clk); #1;
         awvalid = 1'b0; wvalid = 1'b0; araddr = 10'h00C; arvalid = 1'b1;
         @(negedge clk);
         check("same_arready", arready, 1);
         @(posedge clk); #1;
         arvalid = 1'b0;
         wait_count(0, bt, "same_b_timeout");
         wait_count(1, rt, "same_r_timeout");
      end
      do_read(10'h00C, 32'h5A5A5A5A, 2'b00);

      // Reset with a read pending and a write half-latched
      rready = 1'b0;
      @(posedge clk); #1;
      araddr = 10'h008; arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0; awaddr = 10'h014; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      check("pre_rst_rvalid", rvalid, 1);
      check("pre_rst_riscv_rst", riscv_rst, 0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_rvalid", rvalid, 0);
      check("mid_rst_bvalid", bvalid, 0);
      check("mid_rst_awready", awready, 0);
      check("mid_rst_wready", wready, 0);
      check("mid_rst_arready", arready, 0);
      check("mid_rst_rdata", rdata, 0);
      check("mid_rst_riscv_rst", riscv_rst, 1);
      check("mid_rst_scratch", scratch_out, 192'h0);
      @(negedge clk);
      rst = 1'b0;
      rready = 1'b1;
      do_write(10'h010, 32'h00000077, 4'hF, 0, 0, 2'b00);
      do_read(10'h010, 32'h00000077, 2'b00);
      do_read(10'h014, 32'h00000000, 2'b00);
      do_read(10'h000, 32'h00000000, 2'b00);
      check("post_rst_riscv_rst", riscv_rst, 1);

      repeat (3) @(posedge clk);
      check("queues_empty", exp_b_q.size() + exp_r_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
